// File: rtl/vpu_dispatch_ctrl.sv
// Dispatch controller between the CPU decode/execute stage and the VPU.
// Launches VPU ops, commits results, counts down WAITs and raises the pipeline stall.
module vpu_dispatch_ctrl #(
    parameter int unsigned WAIT_W  = 11,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_vpu,
    input  logic              blocking,
    input  logic              issue_wait,
    input  logic [WAIT_W-1:0] wait_time,
    input  logic              vpu_sync,
    input  logic              VPU_rdy,
    output logic              STALL,
    output logic              VPU_start,
    output logic              we_VPU,
    output logic              vpu_busy,
    output logic              wait_active,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StCommit,
        StWait
    } state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              blk_q, blk_d;
    logic              timeout_err_q, timeout_err_d;

    logic stall_c;
    logic start_c;
    logic we_c;
    logic any_req;

    assign any_req = issue_vpu | issue_wait | vpu_sync;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        to_cnt_d      = to_cnt_q;
        blk_d         = blk_q;
        timeout_err_d = timeout_err_q;
        stall_c       = 1'b0;
        start_c       = 1'b0;
        we_c          = 1'b0;

        case (state_q)
            StIdle: begin
                // A VPU op wins over a simultaneous WAIT; the WAIT is held off only if blocking.
                if (issue_vpu) begin
                    state_d = StStart;
                    blk_d   = blocking;
                    stall_c = blocking;
                end else if (issue_wait && (wait_time != '0)) begin
                    state_d = StWait;
                    cnt_d   = wait_time - WAIT_W'(1);
                    stall_c = 1'b1;
                end
            end

            StStart: begin
                start_c  = 1'b1;
                to_cnt_d = '0;
                state_d  = StRun;
                stall_c  = blk_q | any_req;
            end

            StRun: begin
                stall_c = blk_q | any_req;
                // Completion on the final timeout cycle still commits.
                if (VPU_rdy) begin
                    state_d = StCommit;
                end else if (to_cnt_q == ToLast) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            StCommit: begin
                we_c    = 1'b1;
                stall_c = blk_q ? 1'b0 : any_req;
                state_d = StIdle;
            end

            StWait: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            blk_q         <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            blk_q         <= blk_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Outputs are forced low while reset is held so an aborted op never strobes.
    always_comb begin
        STALL       = ~rst & stall_c;
        VPU_start   = ~rst & start_c;
        we_VPU      = ~rst & we_c;
        vpu_busy    = ~rst & ((state_q == StStart) | (state_q == StRun) | (state_q == StCommit));
        wait_active = ~rst & (state_q == StWait);
        timeout_err = timeout_err_q;
    end

endmodule

// File: tb/tb_vpu_dispatch_ctrl.sv
// Self-checking bench for vpu_dispatch_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle-level behavioural model.
module tb_vpu_dispatch_ctrl;

    localparam int unsigned WAIT_W  = 11;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_vpu;
    logic              blocking;
    logic              issue_wait;
    logic [WAIT_W-1:0] wait_time;
    logic              vpu_sync;
    logic              VPU_rdy;
    logic              STALL;
    logic              VPU_start;
    logic              we_VPU;
    logic              vpu_busy;
    logic              wait_active;
    logic              timeout_err;

    vpu_dispatch_ctrl #(
        .WAIT_W (WAIT_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_vpu  (issue_vpu),
        .blocking   (blocking),
        .issue_wait (issue_wait),
        .wait_time  (wait_time),
        .vpu_sync   (vpu_sync),
        .VPU_rdy    (VPU_rdy),
        .STALL      (STALL),
        .VPU_start  (VPU_start),
        .we_VPU     (we_VPU),
        .vpu_busy   (vpu_busy),
        .wait_active(wait_active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: m_age = cycles since launch (-1 = no op in flight), m_commit = commit
    // cycle pending, m_wait = remaining WAIT count (-1 = not waiting).
    int m_age    = -1;
    bit m_commit = 1'b0;
    int m_wait   = -1;
    bit m_blk    = 1'b0;
    bit m_terr   = 1'b0;

    bit tr_stall [0:63];
    bit tr_start [0:63];
    bit tr_we    [0:63];
    bit tr_busy  [0:63];
    bit tr_wact  [0:63];
    bit tr_terr  [0:63];

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input bit blk, input bit iw, input int wt,
                         input bit sync, input bit rdy);
        rst        = 1'b0;
        issue_vpu  = iv;
        blocking   = blk;
        issue_wait = iw;
        wait_time  = WAIT_W'(wt);
        vpu_sync   = sync;
        VPU_rdy    = rdy;
    endtask

    // One clock: compare at mid-cycle, then advance the model on the edge.
    task automatic step();
        bit idle, any, e_stall, e_start, e_we, e_busy, e_wact;
        #3;
        idle    = (m_age < 0) && !m_commit && (m_wait < 0);
        any     = issue_vpu | issue_wait | vpu_sync;
        e_start = (m_age == 0);
        e_we    = m_commit;
        e_busy  = (m_age >= 0) || m_commit;
        e_wact  = (m_wait >= 0);
        if (idle)           e_stall = issue_vpu ? blocking : (issue_wait && (wait_time != 0));
        else if (m_age >= 0) e_stall = m_blk | any;
        else if (m_commit)  e_stall = m_blk ? 1'b0 : any;
        else                e_stall = (m_wait != 0);
        if (rst) begin
            e_stall = 0; e_start = 0; e_we = 0; e_busy = 0; e_wact = 0;
        end
        if (chk_en) begin
            check1("STALL", STALL, e_stall);
            check1("VPU_start", VPU_start, e_start);
            check1("we_VPU", we_VPU, e_we);
            check1("vpu_busy", vpu_busy, e_busy);
            check1("wait_active", wait_active, e_wact);
            check1("timeout_err", timeout_err, m_terr);
        end
        if (cyc < 64) begin
            tr_stall[cyc] = STALL;
            tr_start[cyc] = VPU_start;
            tr_we[cyc]    = we_VPU;
            tr_busy[cyc]  = vpu_busy;
            tr_wact[cyc]  = wait_active;
            tr_terr[cyc]  = timeout_err;
        end
        @(posedge clk);
        if (rst) begin
            m_age = -1; m_commit = 0; m_wait = -1; m_blk = 0; m_terr = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age >= 1) begin
            if (VPU_rdy) begin
                m_age = -1; m_commit = 1;
            end else if (m_age == int'(TIMEOUT)) begin
                m_age = -1; m_terr = 1;
            end else begin
                m_age++;
            end
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_wait >= 0) begin
            m_wait = (m_wait == 0) ? -1 : m_wait - 1;
        end else if (issue_vpu) begin
            m_age = 0; m_blk = blocking;
        end else if (issue_wait && (wait_time != 0)) begin
            m_wait = int'(wait_time) - 1;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int bias;
        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;

        // Reset state
        cyc = 0;
        drive(0, 0, 0, 0, 0, 1);
        step();
        check1("rst_busy", tr_busy[0], 1'b0);
        check1("rst_terr", tr_terr[0], 1'b0);
        check1("rst_wact", tr_wact[0], 1'b0);

        // T1: blocking op, rdy low c2-c5, high c6
        cyc = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c <= 7) drive(1, 1, 0, 0, 0, (c <= 1) || (c >= 6));
            else        drive(0, 0, 0, 0, 0, 1);
            step();
        end
        for (int c = 0; c <= 8; c++) begin
            check1($sformatf("t1_start[c%0d]", c), tr_start[c], c == 1);
            check1($sformatf("t1_stall[c%0d]", c), tr_stall[c], c <= 6);
            check1($sformatf("t1_we[c%0d]", c), tr_we[c], c == 7);
        end
        check1("t1_idle_c8", tr_busy[8], 1'b0);

        // T2: non-blocking op, vpu_sync from c1 to c6, rdy at c4
        cyc = 0;
        for (int c = 0; c <= 7; c++) begin
            drive(c == 0, 0, 0, 0, (c >= 1) && (c <= 6), (c <= 1) || (c >= 4));
            step();
        end
        for (int c = 0; c <= 6; c++)
            check1($sformatf("t2_stall[c%0d]", c), tr_stall[c], (c >= 1) && (c <= 5));
        check1("t2_we_c5", tr_we[5], 1'b1);

        // T3: WAIT 3, then WAIT 0
        cyc = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c <= 3)      drive(0, 0, 1, 3, 0, 1);
            else if (c == 5) drive(0, 0, 1, 0, 0, 1);
            else             drive(0, 0, 0, 0, 0, 1);
            step();
        end
        for (int c = 0; c <= 6; c++) begin
            check1($sformatf("t3_stall[c%0d]", c), tr_stall[c], c <= 2);
            check1($sformatf("t3_wact[c%0d]", c), tr_wact[c], (c >= 1) && (c <= 3));
        end

        // T4: timeout with rdy stuck low, then a clean relaunch
        cyc = 0;
        for (int c = 0; c <= 16; c++) begin
            if (c <= 9)       drive(1, 1, 0, 0, 0, 0);
            else if (c == 12) drive(1, 0, 0, 0, 0, 0);
            else              drive(0, 0, 0, 0, 0, c == 14);
            step();
        end
        for (int c = 0; c <= 16; c++) begin
            check1($sformatf("t4_terr[c%0d]", c), tr_terr[c], c >= 10);
            check1($sformatf("t4_we[c%0d]", c), tr_we[c], c == 15);
            check1($sformatf("t4_start[c%0d]", c), tr_start[c], (c == 1) || (c == 13));
        end
        for (int c = 1; c <= 10; c++)
            check1($sformatf("t4_busy[c%0d]", c), tr_busy[c], c <= 9);
        check1("t4_stall_c9", tr_stall[9], 1'b1);
        check1("t4_stall_c10", tr_stall[10], 1'b0);

        // T5: reset during RUN, then a clean restart
        cyc = 0;
        for (int c = 0; c <= 9; c++) begin
            if (c <= 3)      drive(1, 1, 0, 0, 0, 0);
            else if (c == 5) drive(1, 0, 0, 0, 0, 0);
            else             drive(0, 0, 0, 0, 0, c >= 7);
            if (c == 3) rst = 1'b1;
            step();
        end
        check1("t5_rst_stall", tr_stall[3], 1'b0);
        check1("t5_rst_busy", tr_busy[3], 1'b0);
        check1("t5_post_busy", tr_busy[4], 1'b0);
        check1("t5_post_terr", tr_terr[4], 1'b0);
        for (int c = 3; c <= 9; c++) begin
            check1($sformatf("t5_start[c%0d]", c), tr_start[c], c == 6);
            check1($sformatf("t5_we[c%0d]", c), tr_we[c], c == 8);
        end

        // T6: VPU op and WAIT together with blocking=1
        cyc = 0;
        for (int c = 0; c <= 7; c++) begin
            if (c <= 3)      drive(1, 1, 1, 2, 0, 1);
            else if (c <= 6) drive(0, 0, 1, 2, 0, 1);
            else             drive(0, 0, 0, 0, 0, 1);
            step();
        end
        for (int c = 0; c <= 7; c++) begin
            check1($sformatf("t6_start[c%0d]", c), tr_start[c], c == 1);
            check1($sformatf("t6_stall[c%0d]", c), tr_stall[c], (c <= 2) || (c == 4) || (c == 5));
            check1($sformatf("t6_wact[c%0d]", c), tr_wact[c], (c == 5) || (c == 6));
        end
        check1("t6_we_c3", tr_we[3], 1'b1);

        // Randomized traffic against the model
        bias = 5;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 200) == 0) bias = $urandom_range(0, 10);
            drive($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) < bias);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
